// File: rtl/dds_sweep_ctrl.sv
// Linear frequency sweep (chirp) sequencer driving the DDS core's f_word/pword/dds_en.
// Optional triangular up/down sweeps with a sweep_dir output when SWEEP_BIDIR_EN is defined.
module dds_sweep_ctrl #(
    parameter int FW_W    = 17,
    parameter int PW_W    = 12,
    parameter int DWELL_W = 16,
    parameter int DDS_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [FW_W-1:0]    cfg_f_start,
    input  logic [FW_W-1:0]    cfg_f_stop,
    input  logic [FW_W-1:0]    cfg_f_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [PW_W-1:0]    cfg_pword,
    input  logic [7:0]         cfg_nsweep,
    output logic [FW_W-1:0]    f_word,
    output logic [PW_W-1:0]    pword,
    output logic               dds_en,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic               sample_vld,
`ifdef SWEEP_BIDIR_EN
    output logic               sweep_dir,
`endif
    output logic [7:0]         sweep_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_WRAP   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]         state;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [FW_W-1:0]    sh_start;
    logic [FW_W-1:0]    sh_stop;
    logic [FW_W-1:0]    sh_step;
    logic [DWELL_W-1:0] sh_dwell;
    logic [PW_W-1:0]    sh_pword;
    logic [7:0]         sh_nsweep;
    logic               dir;

    logic [FW_W:0]      sum_up;
    logic [FW_W-1:0]    next_up;
    logic [8:0]         cnt_sum;
    logic [7:0]         cnt_sat;
    logic               last_sweep;
    logic               dwell_end;

    // Extra MSB catches carry-out, so an overflowing step clamps instead of wrapping low.
    assign sum_up     = {1'b0, f_word} + {1'b0, sh_step};
    assign next_up    = (sum_up > {1'b0, sh_stop}) ? sh_stop : sum_up[FW_W-1:0];
    assign cnt_sum    = {1'b0, sweep_cnt} + 9'd1;
    assign cnt_sat    = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    assign last_sweep = (sh_nsweep != 8'd0) && (cnt_sum == {1'b0, sh_nsweep});
    assign dwell_end  = (dwell_cnt == sh_dwell);

`ifdef SWEEP_BIDIR_EN
    logic [FW_W:0] diff_dn;
    logic          down_done;

    // The down leg ends instead of landing on f_start; WRAP reloads f_start so it dwells once.
    assign diff_dn   = {1'b0, f_word} - {1'b0, sh_step};
    assign down_done = diff_dn[FW_W] || (diff_dn[FW_W-1:0] <= sh_start);
    assign sweep_dir = dir;
`endif

    // NOTE: all state here updates with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            dwell_cnt <= '0;
            sh_start  <= '0;
            sh_stop   <= '0;
            sh_step   <= '0;
            sh_dwell  <= '0;
            sh_pword  <= '0;
            sh_nsweep <= '0;
            dir       <= 1'b0;
            f_word    <= '0;
            pword     <= '0;
            dds_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            sweep_cnt <= '0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            if (state == S_IDLE) begin
                if (start) begin
                    if (cfg_f_stop >= cfg_f_start) begin
                        sh_start  <= cfg_f_start;
                        sh_stop   <= cfg_f_stop;
                        sh_step   <= cfg_f_step;
                        sh_dwell  <= cfg_dwell;
                        sh_pword  <= cfg_pword;
                        sh_nsweep <= cfg_nsweep;
                        busy      <= 1'b1;
                        state     <= S_LOAD;
                    end else begin
                        cfg_err <= 1'b1;
                    end
                end
            end else if (abort) begin
                state  <= S_IDLE;
                dds_en <= 1'b0;
                f_word <= '0;
                busy   <= 1'b0;
                dir    <= 1'b0;
            end else begin
                case (state)
                    S_LOAD: begin
                        f_word    <= sh_start;
                        pword     <= sh_pword;
                        dwell_cnt <= '0;
                        dds_en    <= 1'b1;
                        sweep_cnt <= '0;
                        dir       <= 1'b0;
                        state     <= S_RUN;
                    end
                    S_RUN: begin
                        if (dwell_end) begin
                            dwell_cnt <= '0;
`ifdef SWEEP_BIDIR_EN
                            if (sh_step == '0) begin
                                state <= S_WRAP;
                            end else if (dir || (f_word == sh_stop)) begin
                                if (down_done) begin
                                    state <= S_WRAP;
                                end else begin
                                    f_word <= diff_dn[FW_W-1:0];
                                    dir    <= 1'b1;
                                end
                            end else begin
                                f_word <= next_up;
                            end
`else
                            if ((f_word == sh_stop) || (sh_step == '0)) begin
                                state <= S_WRAP;
                            end else begin
                                f_word <= next_up;
                            end
`endif
                        end else begin
                            dwell_cnt <= dwell_cnt + DWELL_W'(1);
                        end
                    end
                    S_WRAP: begin
                        sweep_cnt <= cnt_sat;
                        dir       <= 1'b0;
                        if (last_sweep) begin
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            f_word    <= sh_start;
                            dwell_cnt <= '0;
                            state     <= S_RUN;
                        end
                    end
                    S_FINISH: begin
                        dds_en <= 1'b0;
                        f_word <= '0;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end
                    default: begin
                        dds_en <= 1'b0;
                        f_word <= '0;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Valid strobe tracks dds_en through the DDS ROM pipeline depth.
    logic [DDS_LAT-1:0] vld_sr;

    generate
        if (DDS_LAT > 1) begin : g_vld_multi
            always_ff @(posedge clk) begin
                if (rst) vld_sr <= '0;
                else     vld_sr <= {vld_sr[DDS_LAT-2:0], dds_en};
            end
        end else begin : g_vld_single
            always_ff @(posedge clk) begin
                if (rst) vld_sr <= '0;
                else     vld_sr <= dds_en;
            end
        end
    endgenerate

    assign sample_vld = vld_sr[DDS_LAT-1];

endmodule
